// File: rtl/ysyx_24080034_pkg.sv
// Shared definitions for the writeback arbiter slice: default widths and source ids.
package ysyx_24080034_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned PC_WIDTH_DEF   = 32;

  // Bit positions of each producer in request/grant vectors.
  localparam int unsigned SRC_EXU = 0;
  localparam int unsigned SRC_LSU = 1;

endpackage

// File: rtl/ysyx_24080034_rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr=0 prefers EXU, flips after each grant.
module ysyx_24080034_rr_arb2
  import ysyx_24080034_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       rr_ptr
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt[SRC_EXU] = 1'b1;
      2'b10:   gnt[SRC_LSU] = 1'b1;
      2'b11: begin
        if (rr_ptr_q) gnt[SRC_LSU] = 1'b1;
        else          gnt[SRC_EXU] = 1'b1;
      end
      default: gnt = '0;
    endcase
  end

  // A grant is always a transfer: the stage never stalls, so requesters are accepted at once.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[SRC_EXU])      rr_ptr_d = 1'b1;
    else if (gnt[SRC_LSU]) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/ysyx_24080034_wb_arbiter.sv
// Writeback stage: arbitrates EXU/LSU results onto the regfile write port,
// emits commit pulses and tracks pending destination registers.
module ysyx_24080034_wb_arbiter
  import ysyx_24080034_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic [PC_WIDTH-1:0]      exu_pc,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic [PC_WIDTH-1:0]      lsu_pc,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_rd,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     commit_valid,
  output logic [PC_WIDTH-1:0]      commit_pc,
  output logic [2**ADDR_WIDTH-1:0] busy
);

  localparam int unsigned NREGS = 2**ADDR_WIDTH;

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  rr_ptr;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PC_WIDTH-1:0]   sel_pc;

  logic                  rf_wen_q,       rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q,     rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q,     rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [PC_WIDTH-1:0]   commit_pc_q,    commit_pc_d;
  logic [NREGS-1:0]      busy_q,         busy_d;

  assign req[SRC_EXU] = exu_valid;
  assign req[SRC_LSU] = lsu_valid;

  ysyx_24080034_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .rr_ptr (rr_ptr)
  );

  assign exu_ready = gnt[SRC_EXU];
  assign lsu_ready = gnt[SRC_LSU];
  assign xfer      = |gnt;

  always_comb begin
    sel_rd   = exu_rd;
    sel_data = exu_data;
    sel_pc   = exu_pc;
    if (gnt[SRC_LSU]) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
      sel_pc   = lsu_pc;
    end
  end

  always_comb begin
    rf_wen_d       = xfer && (sel_rd != '0);
    commit_valid_d = xfer;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_pc_d    = commit_pc_q;
    if (xfer) begin
      rf_waddr_d  = sel_rd;
      rf_wdata_d  = sel_data;
      commit_pc_d = sel_pc;
    end
  end

  // Clear before set so a same-cycle reissue of the retiring register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      busy_q         <= '0;
    end else begin
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      busy_q         <= busy_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign busy         = busy_q;

  // rr_ptr is internal to the arbiter; exposed here only for structural visibility.
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

endmodule
